// File: rtl/color_palette_lut.sv
// color_palette_lut: writable palette lookup followed by a global brightness
// scale. Two pipeline stages: palette read, then per-channel scaling.
module color_palette_lut #(
  parameter int COLOR_WIDTH   = 3,
  parameter int CHANNEL_WIDTH = 8,
  parameter int BRIGHT_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [COLOR_WIDTH-1:0]     index,
  input  logic                       wr_en,
  input  logic [COLOR_WIDTH-1:0]     wr_index,
  input  logic [3*CHANNEL_WIDTH-1:0] wr_rgb,
  input  logic [BRIGHT_WIDTH-1:0]    bright,
  output logic                       out_valid,
  output logic [CHANNEL_WIDTH-1:0]   r,
  output logic [CHANNEL_WIDTH-1:0]   g,
  output logic [CHANNEL_WIDTH-1:0]   b
);

  localparam int DEPTH    = 1 << COLOR_WIDTH;
  localparam int RGB_W    = 3 * CHANNEL_WIDTH;
  localparam int PROD_W   = CHANNEL_WIDTH + BRIGHT_WIDTH;

  localparam logic [CHANNEL_WIDTH-1:0] CH_MAX  = {CHANNEL_WIDTH{1'b1}};
  localparam logic [CHANNEL_WIDTH-1:0] CH_ZERO = {CHANNEL_WIDTH{1'b0}};

  logic [RGB_W-1:0]        palette [DEPTH];
  logic                    v1;
  logic [RGB_W-1:0]        e1;
  logic [BRIGHT_WIDTH-1:0] bright1;

  // Power-on palette contents: black, white, red, green, blue, then black.
  function automatic logic [RGB_W-1:0] default_entry(input int i);
    logic [RGB_W-1:0] entry;
    case (i)
      1:       entry = {CH_MAX,  CH_MAX,  CH_MAX};
      2:       entry = {CH_MAX,  CH_ZERO, CH_ZERO};
      3:       entry = {CH_ZERO, CH_MAX,  CH_ZERO};
      4:       entry = {CH_ZERO, CH_ZERO, CH_MAX};
      default: entry = {RGB_W{1'b0}};
    endcase
    return entry;
  endfunction

  // Multiply by (bright+1) then drop BRIGHT_WIDTH bits, so all-ones is unity
  // gain and zero still passes c >> BRIGHT_WIDTH.
  function automatic logic [CHANNEL_WIDTH-1:0] scale(
    input logic [CHANNEL_WIDTH-1:0] c,
    input logic [BRIGHT_WIDTH-1:0]  br
  );
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(c) * PROD_W'({1'b0, br} + 1'b1);
    return CHANNEL_WIDTH'(prod >> BRIGHT_WIDTH);
  endfunction

  // Palette storage: reset restores defaults, writes land on the clock edge so
  // a same-cycle lookup of the same entry still sees the old value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        palette[i] <= default_entry(i);
      end
    end else if (wr_en) begin
      palette[wr_index] <= wr_rgb;
    end
  end

  // Stage 1: fetch the entry and latch brightness alongside the pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1      <= 1'b0;
      e1      <= {RGB_W{1'b0}};
      bright1 <= {BRIGHT_WIDTH{1'b0}};
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        e1      <= palette[index];
        bright1 <= bright;
      end
    end
  end

  // Stage 2: scale each channel; outputs hold their last colour on bubbles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      r         <= CH_ZERO;
      g         <= CH_ZERO;
      b         <= CH_ZERO;
    end else begin
      out_valid <= v1;
      if (v1) begin
        r <= scale(e1[3*CHANNEL_WIDTH-1:2*CHANNEL_WIDTH], bright1);
        g <= scale(e1[2*CHANNEL_WIDTH-1:CHANNEL_WIDTH], bright1);
        b <= scale(e1[CHANNEL_WIDTH-1:0], bright1);
      end
    end
  end

endmodule

// File: tb/tb_color_palette_lut.sv
// Directed testbench for color_palette_lut with hand-computed expectations.
module tb_color_palette_lut;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic [2:0]  index;
  logic        wr_en;
  logic [2:0]  wr_index;
  logic [23:0] wr_rgb;
  logic [3:0]  bright;
  logic        out_valid;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;

  int errors = 0;
  int checks = 0;

  color_palette_lut #(
    .COLOR_WIDTH(3),
    .CHANNEL_WIDTH(8),
    .BRIGHT_WIDTH(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .index(index),
    .wr_en(wr_en),
    .wr_index(wr_index),
    .wr_rgb(wr_rgb),
    .bright(bright),
    .out_valid(out_valid),
    .r(r),
    .g(g),
    .b(b)
  );

  // 10 time-unit clock; stimulus and sampling happen on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [2:0] idx, input logic we,
                       input logic [2:0] widx, input logic [23:0] wrgb,
                       input logic [3:0] br);
    in_valid = v;
    index    = idx;
    wr_en    = we;
    wr_index = widx;
    wr_rgb   = wrgb;
    bright   = br;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    tick();
    checks++;
    if ({out_valid, r, g, b} !== 25'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", {out_valid, r, g, b}, 25'h0);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_default_palette();
    logic [23:0] exp_rgb [6];
    exp_rgb[0] = 24'h000000;
    exp_rgb[1] = 24'hFFFFFF;
    exp_rgb[2] = 24'hFF0000;
    exp_rgb[3] = 24'h00FF00;
    exp_rgb[4] = 24'h0000FF;
    exp_rgb[5] = 24'h000000;
    for (int c = 0; c < 8; c++) begin
      if (c >= 2) begin
        checks++;
        if ({out_valid, r, g, b} !== {1'b1, exp_rgb[c-2]}) begin
          errors++;
          $display("[TB] FAIL default_idx%0d: got %h expected %h", c - 2,
                   {out_valid, r, g, b}, {1'b1, exp_rgb[c-2]});
        end
      end
      if (c < 6) drive(1'b1, 3'(c), 1'b0, 3'd0, 24'h0, 4'hF);
      else       drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
      tick();
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL default_drain_valid: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_runtime_write();
    drive(1'b0, 3'd0, 1'b1, 3'd5, 24'h123456, 4'hF);
    tick();
    drive(1'b1, 3'd5, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_latency: got out_valid %b expected 0 after one cycle", out_valid);
    end
    tick();
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'h123456}) begin
      errors++;
      $display("[TB] FAIL runtime_write: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'h123456});
    end
  endtask

  task automatic test_collision();
    drive(1'b1, 3'd1, 1'b1, 3'd1, 24'h00FF00, 4'hF);
    tick();
    drive(1'b1, 3'd1, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'hFFFFFF}) begin
      errors++;
      $display("[TB] FAIL collision_old: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'hFFFFFF});
    end
    tick();
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'h00FF00}) begin
      errors++;
      $display("[TB] FAIL collision_new: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'h00FF00});
    end
  endtask

  task automatic test_brightness();
    // restore white at index 1
    drive(1'b0, 3'd0, 1'b1, 3'd1, 24'hFFFFFF, 4'hF);
    tick();
    // bright 7 then switch to F while the pixel is in flight
    drive(1'b1, 3'd1, 1'b0, 3'd0, 24'h0, 4'h7);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'h7F7F7F}) begin
      errors++;
      $display("[TB] FAIL bright_7: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'h7F7F7F});
    end
    // bright 0 on white, then bright 3 on 123456, back-to-back
    drive(1'b1, 3'd1, 1'b0, 3'd0, 24'h0, 4'h0);
    tick();
    drive(1'b1, 3'd5, 1'b0, 3'd0, 24'h0, 4'h3);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'h0F0F0F}) begin
      errors++;
      $display("[TB] FAIL bright_0: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'h0F0F0F});
    end
    tick();
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'h040D15}) begin
      errors++;
      $display("[TB] FAIL bright_3: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'h040D15});
    end
  endtask

  task automatic test_bubbles();
    logic        vpat [3];
    logic [2:0]  ipat [3];
    logic [24:0] exp_out [3];
    vpat[0] = 1'b1; ipat[0] = 3'd2; exp_out[0] = {1'b1, 24'hFF0000};
    vpat[1] = 1'b0; ipat[1] = 3'd4; exp_out[1] = {1'b0, 24'hFF0000};
    vpat[2] = 1'b1; ipat[2] = 3'd3; exp_out[2] = {1'b1, 24'h00FF00};
    tick();
    for (int c = 0; c < 5; c++) begin
      if (c >= 2) begin
        checks++;
        if ({out_valid, r, g, b} !== exp_out[c-2]) begin
          errors++;
          $display("[TB] FAIL bubble_%0d: got %h expected %h", c - 2,
                   {out_valid, r, g, b}, exp_out[c-2]);
        end
      end
      if (c < 3) drive(vpat[c], ipat[c], 1'b0, 3'd0, 24'h0, 4'hF);
      else       drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
      tick();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 3'd0, 1'b1, 3'd2, 24'h000000, 4'hF);
    tick();
    drive(1'b1, 3'd1, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    drive(1'b1, 3'd1, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'hFFFFFF}) begin
      errors++;
      $display("[TB] FAIL pre_reset_pixel: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'hFFFFFF});
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, r, g, b} !== 25'h0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", {out_valid, r, g, b}, 25'h0);
    end
    tick();
    reset = 1'b0;
    drive(1'b1, 3'd2, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    drive(1'b1, 3'd5, 1'b0, 3'd0, 24'h0, 4'hF);
    tick();
    drive(1'b0, 3'd0, 1'b0, 3'd0, 24'h0, 4'hF);
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'hFF0000}) begin
      errors++;
      $display("[TB] FAIL reset_restores_idx2: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'hFF0000});
    end
    tick();
    checks++;
    if ({out_valid, r, g, b} !== {1'b1, 24'h000000}) begin
      errors++;
      $display("[TB] FAIL reset_clears_idx5: got %h expected %h", {out_valid, r, g, b}, {1'b1, 24'h000000});
    end
  endtask

  // Scenario sequence followed by the summary.
  initial begin
    $display("[TB] starting color_palette_lut bench");
    test_reset();
    test_default_palette();
    test_runtime_write();
    test_collision();
    test_brightness();
    test_bubbles();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/color_palette_lut.md
Name: color_palette_lut

Overview:
- Programmable palette lookup with a 2-stage pipeline. Converts a streamed colour index to 24-bit-class RGB through a writable palette RAM, then applies a global brightness scale.
- Sits between the frame-buffer or pixel generator and the VGA output.
- Reset loads the standard palette: black, white, red, green, blue. All other entries reset to black.
- Software or FSM logic can rewrite any entry at runtime without stalling the pixel stream.

Parameters:
- COLOR_WIDTH, 3, index width. Palette depth is 2**COLOR_WIDTH entries, minimum 3.
- CHANNEL_WIDTH, 8, bits per R/G/B channel.
- BRIGHT_WIDTH, 4, width of the brightness control.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  index is valid this cycle.
- index  input  COLOR_WIDTH  colour index to look up.
- wr_en  input  1  palette write strobe.
- wr_index  input  COLOR_WIDTH  palette entry to write.
- wr_rgb  input  3*CHANNEL_WIDTH  new entry, packed {r,g,b}.
- bright  input  BRIGHT_WIDTH  global brightness; all-ones is full intensity.
- out_valid  output  1  r/g/b are valid this cycle.
- r, g, b  output  CHANNEL_WIDTH each  scaled colour channels.

Behaviour:
- Reset (asserted asynchronously, held while high):
  - out_valid=0, r=g=b=0, stage-1 valid=0.
  - Palette entry 0 = black (all 0).
  - Entry 1 = white (all channels max).
  - Entry 2 = red (r=max).
  - Entry 3 = green (g=max).
  - Entry 4 = blue (b=max), only if depth > 4.
  - All remaining entries = 0.
  - Reset mid-stream discards in-flight pixels and reverts all runtime writes.
- Stage 1 (edge N):
  - v1 <= in_valid.
  - e1 <= palette[index], registered only when in_valid=1.
  - bright1 <= bright, captured with the pixel so brightness changes apply per pixel, not mid-pipe.
- Stage 2 (edge N+1):
  - out_valid <= v1.
  - Each channel <= (c * (bright1 + 1)) >> BRIGHT_WIDTH, computed at CHANNEL_WIDTH+BRIGHT_WIDTH bits and truncated to CHANNEL_WIDTH.
  - When v1=0, r/g/b hold their previous values.
- Latency: exactly 2 cycles from in_valid to out_valid. Throughput is 1 pixel/cycle; there is no backpressure.
- bright=all-ones gives output equal to the entry exactly. bright=0 gives c>>BRIGHT_WIDTH, which is not zero by design.
- Palette write:
  - On an edge with wr_en=1, palette[wr_index] <= wr_rgb.
  - Write and read are independent and can occur in the same cycle.
- Same-cycle read and write to the same index: the read returns the OLD entry (read-before-write). The new value is visible to lookups from the next cycle onward.
- Palette storage is a register array (no RAM inference requirement). Indices wrap naturally within COLOR_WIDTH bits, so no out-of-range case exists.
- in_valid=0 cycles produce bubbles: out_valid=0 two cycles later, with no other effect.

Test Plan:
- Reset default palette:
  - Stimulus: release reset, bright=4'hF, stream indices 0,1,2,3,4 back-to-back.
  - Required: out_valid high on cycles 2..6 with rgb 000000, FFFFFF, FF0000, 00FF00, 0000FF; index 5 gives 000000.
- Runtime write:
  - Stimulus: write index 5 = 24'h123456, then on the next cycle read index 5.
  - Required: 123456 appears 2 cycles later.
- Same-cycle collision:
  - Stimulus: write index 1 = 24'h00FF00 while reading index 1 in the same cycle.
  - Required: output FFFFFF; a read of index 1 on the following cycle outputs 00FF00.
- Brightness:
  - Stimulus: bright=4'h7, read index 1.
  - Required: each channel = (255*8)>>4 = 8'h7F.
  - Stimulus: change bright to 4'hF on the cycle after the read.
  - Required: in-flight pixel still outputs 7F7F7F.
- Bubbles:
  - Stimulus: in_valid pattern 1,0,1.
  - Required: out_valid pattern 1,0,1 delayed by 2 cycles; r/g/b hold during the 0 cycle.
- Reset mid-operation:
  - Stimulus: write index 2 = 24'h0, assert reset asynchronously while pixels are in flight, release, read index 2.
  - Required: out_valid drops immediately with no clock edge; after release, index 2 reads FF0000.
